// File: rtl/comp_mult_pkg.sv
// Shared types and constants for the shift-add multiplier.
// The state encoding and counter sizing match the companion divider.
package comp_mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    // The counter only has to reach WIDTH-1.
    // It is sized to hold WIDTH so that it matches the divider.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/comp_multiplier_adder.sv
// Combinational WIDTH-bit unsigned adder with carry out.
// Its interface mirrors the divider ALU.
module mult_adder
    import comp_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] result,
    output logic             carry,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2
);

    always_comb begin
        {carry, result} = {1'b0, src1} + {1'b0, src2};
    end

endmodule

// File: rtl/comp_multiplier.sv
// Unsigned sequential shift-add multiplier with a Run/Rdy handshake.
// Optional build macro: COMP_MULT_ZERO_SKIP_EN (zero operands finish on the start edge).
module comp_multiplier
    import comp_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 Rst,
    input  logic                 Run,
    input  logic [WIDTH-1:0]     Mcand,
    input  logic [WIDTH-1:0]     Mplr,
    output logic [2*WIDTH-1:0]   P,
    output logic                 Rdy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mult_state_e          state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_d;
    logic                 rdy_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 c;
    logic                 zero_skip;

    assign addend = P[0] ? mcand_q : '0;

    mult_adder #(.WIDTH(WIDTH)) u_adder (
        .result (sum),
        .carry  (c),
        .src1   (P[2*WIDTH-1:WIDTH]),
        .src2   (addend)
    );

`ifdef COMP_MULT_ZERO_SKIP_EN
    assign zero_skip = (Mcand == '0) || (Mplr == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!Rst) begin
            state_q <= IDLE;
            P       <= '0;
            Rdy     <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
        end else begin
            state_q <= state_d;
            P       <= p_d;
            Rdy     <= rdy_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = P;
        rdy_d   = Rdy;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        case (state_q)
            IDLE, DONE: begin
                if (Run) begin
                    mcand_d = Mcand;
                    cnt_d   = '0;
                    if (zero_skip) begin
                        p_d     = '0;
                        state_d = DONE;
                        rdy_d   = 1'b1;
                    end else begin
                        p_d     = {{WIDTH{1'b0}}, Mplr};
                        state_d = BUSY;
                        rdy_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
                // The carry out enters P[2W-1] through the one-bit right shift.
                p_d   = {c, sum, P[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rdy_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_comp_multiplier.sv
// Scoreboard bench for comp_multiplier.
// Starts push the expected product and latency; a monitor checks on each rising edge of Rdy.
module tb_comp_multiplier;

    localparam int W        = 32;
    localparam int FULL_LAT = W + 1;
`ifdef COMP_MULT_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = W + 1;
`endif

    logic           clk   = 1'b0;
    logic           Rst   = 1'b0;
    logic           Run   = 1'b0;
    logic [W-1:0]   Mcand = '0;
    logic [W-1:0]   Mplr  = '0;
    logic [2*W-1:0] P;
    logic           Rdy;

    typedef struct {
        logic [2*W-1:0] p;
        int             lat;
        int             start_edge;
        string          name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    logic rdy_prev = 1'b0;

    comp_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .Rst   (Rst),
        .Run   (Run),
        .Mcand (Mcand),
        .Mplr  (Mplr),
        .P     (P),
        .Rdy   (Rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check64(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of Rdy must match the oldest outstanding start.
    always @(negedge clk) begin
        if (Rdy && !rdy_prev) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rdy: got Rdy=1 with P=0x%h, expected no completion", P);
            end else begin
                mon_e = sb.pop_front();
                check64({mon_e.name, "_product"}, P, mon_e.p);
                check_int({mon_e.name, "_latency"}, edge_cnt - mon_e.start_edge + 1, mon_e.lat);
            end
        end
        rdy_prev = Rdy;
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp, input int lat, input string name);
        exp_t e;
        @(negedge clk);
        Mcand = a;
        Mplr  = b;
        Run   = 1'b1;
        e.p = exp;
        e.lat = lat;
        e.start_edge = edge_cnt + 1;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        Run   = 1'b0;
        Mcand = 32'hA5A5_5A5A;
        Mplr  = 32'h3C3C_C3C3;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 100 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no Rdy within 100 cycles, expected completion", name);
            sb.delete();
        end
    endtask

    initial begin
        Rst = 1'b0;
        repeat (3) @(negedge clk);
        check64("reset_p", P, '0);
        check_int("reset_rdy", int'(Rdy), 0);
        Rst = 1'b1;

        start_op(32'd3, 32'd5, 64'd15, FULL_LAT, "mul_3x5");
        wait_done("mul_3x5");

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, FULL_LAT, "mul_max");
        wait_done("mul_max");

        // Run toggles and operands change while BUSY; neither may disturb the operation.
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, FULL_LAT, "mul_busy_noise");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            Run   = (i % 2) == 0;
            Mcand = $urandom;
            Mplr  = $urandom;
        end
        @(negedge clk);
        Run = 1'b0;
        wait_done("mul_busy_noise");

        start_op(32'd7, 32'd6, 64'd42, FULL_LAT, "mul_restart");
        check_int("restart_rdy_drop", int'(Rdy), 0);
        wait_done("mul_restart");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check64("done_hold_p", P, 64'd42);
            check_int("done_hold_rdy", int'(Rdy), 1);
        end

        // Abort an operation with reset partway through; it must not complete.
        @(negedge clk);
        Mcand = 32'd9;
        Mplr  = 32'd9;
        Run   = 1'b1;
        @(negedge clk);
        Run = 1'b0;
        repeat (10) @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);
        Rst = 1'b1;
        check64("midop_reset_p", P, '0);
        check_int("midop_reset_rdy", int'(Rdy), 0);
        repeat (3) @(negedge clk);
        check_int("idle_after_reset_rdy", int'(Rdy), 0);

        start_op(32'd0, 32'h0000_DEAD, 64'd0, ZERO_LAT, "mul_zero");
        wait_done("mul_zero");

        start_op(32'd2, 32'd2, 64'd4, FULL_LAT, "mul_2x2");
        wait_done("mul_2x2");

        check_int("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
